// File: rtl/tinyqv_fetch_buffer_if.sv
// Bus bundle between the fetch buffer, the memory controller and the decoder/core.
interface tinyqv_fetch_buffer_if;
  logic        fetch_start;
  logic [22:0] fetch_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_data_ready;
  logic [31:0] instr;
  logic [22:0] instr_pc;
  logic        instr_valid;
  logic        instr_complete;
  logic [1:0]  instr_len;
  logic        branch;
  logic [22:0] branch_addr;

  // Fetch buffer side
  modport slave (
    output fetch_start, fetch_addr, mem_data_ready, instr, instr_pc, instr_valid,
    input  mem_data_in, mem_data_valid, instr_complete, instr_len, branch, branch_addr
  );

  // Memory controller / decoder / core side
  modport master (
    input  fetch_start, fetch_addr, mem_data_ready, instr, instr_pc, instr_valid,
    output mem_data_in, mem_data_valid, instr_complete, instr_len, branch, branch_addr
  );
endinterface

// File: rtl/tinyqv_fetch_buffer.sv
// Halfword prefetch FIFO presenting {hw1, hw0} and its PC to the decoder.
// Every output is a flop loaded from next-state, so no input reaches an output
// combinationally.
module tinyqv_fetch_buffer #(
  parameter int unsigned DEPTH_HW = 4
) (
  input logic                  clk,
  input logic                  rst,
  tinyqv_fetch_buffer_if.slave bus
);

  localparam int unsigned AW = (DEPTH_HW > 1) ? $clog2(DEPTH_HW) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 23;
  localparam int unsigned HW = 16;
  localparam int unsigned IW = 32;

  logic [HW-1:0] buf_q [DEPTH_HW];
  logic [HW-1:0] buf_d [DEPTH_HW];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] fetch_addr_q, fetch_addr_d;
  logic          fetch_start_q, fetch_start_d;
  logic          ready_q, ready_d;
  logic          instr_valid_q, instr_valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          restart_q, restart_d;

  logic          push_c;
  logic          retire_c;
  logic          pop_two_c;
  logic [1:0]    pop_hw_c;
  logic [HW-1:0] hw0_c;
  logic [HW-1:0] hw1_c;

  // Next-state: branch flushes, otherwise push/retire update FIFO and PC
  always_comb begin
    buf_d         = buf_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    fetch_start_d = 1'b0;
    restart_d     = 1'b0;

    push_c    = bus.mem_data_valid && ready_q;
    pop_two_c = (bus.instr_len == 2'b10);
    // A 4-byte retire with only one halfword held is not a real instruction
    retire_c  = bus.instr_complete && instr_valid_q &&
                ((bus.instr_len == 2'b01) || pop_two_c) &&
                !(pop_two_c && (count_q == CW'(1)));
    pop_hw_c  = retire_c ? (pop_two_c ? 2'd2 : 2'd1) : 2'd0;

    if (bus.branch) begin
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      pc_d          = bus.branch_addr;
      fetch_start_d = 1'b1;
      fetch_addr_d  = bus.branch_addr;
    end else begin
      if (push_c) begin
        buf_d[wr_ptr_q] = bus.mem_data_in;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      rd_ptr_d = rd_ptr_q + AW'(pop_hw_c);
      pc_d     = pc_q + PW'(pop_hw_c);
      count_d  = count_q + CW'(push_c) - CW'(pop_hw_c);
      // First cycle out of reset kicks off a stream at address 0
      if (restart_q) begin
        fetch_start_d = 1'b1;
        fetch_addr_d  = '0;
      end
    end

    hw0_c         = buf_d[rd_ptr_d];
    hw1_c         = buf_d[rd_ptr_d + AW'(1)];
    ready_d       = (count_d < CW'(DEPTH_HW));
    instr_d       = {hw1_c, hw0_c};
    instr_valid_d = (count_d >= CW'(2)) ||
                    ((count_d != '0) && (hw0_c[1:0] != 2'b11));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_HW; i++) buf_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pc_q          <= '0;
      fetch_addr_q  <= '0;
      fetch_start_q <= 1'b0;
      ready_q       <= 1'b1;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      restart_q     <= 1'b1;
    end else begin
      buf_q         <= buf_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_start_q <= fetch_start_d;
      ready_q       <= ready_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      restart_q     <= restart_d;
    end
  end

  assign bus.fetch_start    = fetch_start_q;
  assign bus.fetch_addr     = fetch_addr_q;
  assign bus.mem_data_ready = ready_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = pc_q;
  assign bus.instr_valid    = instr_valid_q;

endmodule

// File: tb/tb_tinyqv_fetch_buffer.sv
// Directed bench for tinyqv_fetch_buffer.
module tb_tinyqv_fetch_buffer;

  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  tinyqv_fetch_buffer_if bus ();

  tinyqv_fetch_buffer #(.DEPTH_HW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in    = 16'h0;
    bus.instr_complete = 1'b0;
    bus.instr_len      = 2'b00;
    bus.branch         = 1'b0;
    bus.branch_addr    = 23'h0;
  endtask

  task automatic push(input logic [15:0] hw);
    bus.mem_data_valid = 1'b1;
    bus.mem_data_in    = hw;
  endtask

  task automatic complete(input logic [1:0] len);
    bus.instr_complete = 1'b1;
    bus.instr_len      = len;
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    rst     = 1'b1;
    idle();
    tick();
    tick();

    // Reset values
    chk("rst_ready", 32'(bus.mem_data_ready), 32'd1);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_fstart", 32'(bus.fetch_start), 32'd0);
    chk("rst_faddr", 32'(bus.fetch_addr), 32'd0);

    rst = 1'b0;
    tick();
    chk("boot_fstart", 32'(bus.fetch_start), 32'd1);
    chk("boot_faddr", 32'(bus.fetch_addr), 32'd0);
    tick();
    chk("boot_fstart_end", 32'(bus.fetch_start), 32'd0);

    // 32-bit instruction 0x00000513 at pc 0
    push(16'h0513);
    tick();
    chk("t1_half_valid", 32'(bus.instr_valid), 32'd0);
    push(16'h0000);
    tick();
    idle();
    chk("t1_valid", 32'(bus.instr_valid), 32'd1);
    chk("t1_instr", bus.instr, 32'h0000_0513);
    chk("t1_pc", 32'(bus.instr_pc), 32'd0);
    complete(2'b10);
    tick();
    idle();
    chk("t1_pc_after", 32'(bus.instr_pc), 32'd2);
    chk("t1_valid_after", 32'(bus.instr_valid), 32'd0);

    // Compressed instruction with a single halfword held
    push(16'h4501);
    tick();
    idle();
    chk("t2_valid", 32'(bus.instr_valid), 32'd1);
    chk("t2_hw0", 32'(bus.instr[15:0]), 32'h4501);
    complete(2'b01);
    tick();
    idle();
    chk("t2_pc", 32'(bus.instr_pc), 32'd3);
    chk("t2_valid_after", 32'(bus.instr_valid), 32'd0);

    // Fill to capacity; a fifth halfword must be refused
    push(16'h0001); tick();
    push(16'h0002); tick();
    push(16'h0003); tick();
    push(16'h0004); tick();
    chk("t3_full_ready", 32'(bus.mem_data_ready), 32'd0);
    push(16'h0005);
    tick();
    chk("t3_still_full", 32'(bus.mem_data_ready), 32'd0);
    chk("t3_instr_full", bus.instr, 32'h0002_0001);
    complete(2'b10);
    tick();
    idle();
    chk("t3_ready_after", 32'(bus.mem_data_ready), 32'd1);
    chk("t3_instr_next", bus.instr, 32'h0004_0003);
    chk("t3_pc", 32'(bus.instr_pc), 32'd5);
    complete(2'b10);
    tick();
    idle();
    chk("t3_empty_valid", 32'(bus.instr_valid), 32'd0);
    chk("t3_pc2", 32'(bus.instr_pc), 32'd7);

    // Branch beats a concurrent push and retire
    push(16'h4509);
    tick();
    bus.branch      = 1'b1;
    bus.branch_addr = 23'h81;
    push(16'h4511);
    complete(2'b01);
    tick();
    idle();
    chk("t4_valid", 32'(bus.instr_valid), 32'd0);
    chk("t4_pc", 32'(bus.instr_pc), 32'h81);
    chk("t4_fstart", 32'(bus.fetch_start), 32'd1);
    chk("t4_faddr", 32'(bus.fetch_addr), 32'h81);
    chk("t4_ready", 32'(bus.mem_data_ready), 32'd1);
    tick();
    chk("t4_fstart_end", 32'(bus.fetch_start), 32'd0);
    chk("t4_still_empty", 32'(bus.instr_valid), 32'd0);

    // Back-to-back branches: last target wins
    bus.branch      = 1'b1;
    bus.branch_addr = 23'h100;
    tick();
    chk("bb_fstart1", 32'(bus.fetch_start), 32'd1);
    chk("bb_faddr1", 32'(bus.fetch_addr), 32'h100);
    bus.branch_addr = 23'h200;
    tick();
    idle();
    chk("bb_fstart2", 32'(bus.fetch_start), 32'd1);
    chk("bb_faddr2", 32'(bus.fetch_addr), 32'h200);
    chk("bb_pc", 32'(bus.instr_pc), 32'h200);
    tick();
    chk("bb_fstart_end", 32'(bus.fetch_start), 32'd0);

    // Simultaneous push and pop with two compressed instructions held
    push(16'h4501); tick();
    push(16'h4503); tick();
    push(16'h4505);
    complete(2'b01);
    tick();
    idle();
    chk("t5_valid", 32'(bus.instr_valid), 32'd1);
    chk("t5_instr", bus.instr, 32'h4505_4503);
    chk("t5_pc", 32'(bus.instr_pc), 32'h201);
    complete(2'b01);
    tick();
    chk("t5_hw0", 32'(bus.instr[15:0]), 32'h4505);
    chk("t5_pc2", 32'(bus.instr_pc), 32'h202);
    tick();
    idle();
    chk("t5_drained", 32'(bus.instr_valid), 32'd0);
    chk("t5_pc3", 32'(bus.instr_pc), 32'h203);

    // Retire requests that must be ignored
    complete(2'b01);
    tick();
    idle();
    chk("ign_empty_pc", 32'(bus.instr_pc), 32'h203);
    push(16'h0013);
    tick();
    idle();
    complete(2'b10);
    tick();
    idle();
    chk("ign_short_pc", 32'(bus.instr_pc), 32'h203);
    push(16'h0000);
    tick();
    idle();
    chk("ign_instr", bus.instr, 32'h0000_0013);
    chk("ign_valid", 32'(bus.instr_valid), 32'd1);
    complete(2'b10);
    tick();
    idle();
    chk("ign_pc_after", 32'(bus.instr_pc), 32'h205);

    // PC wraps at the top of the address space
    bus.branch      = 1'b1;
    bus.branch_addr = 23'h7F_FFFF;
    tick();
    idle();
    push(16'h4501);
    tick();
    idle();
    chk("wrap_pc_top", 32'(bus.instr_pc), 32'h7F_FFFF);
    complete(2'b01);
    tick();
    idle();
    chk("wrap_pc", 32'(bus.instr_pc), 32'd0);
    chk("wrap_valid", 32'(bus.instr_valid), 32'd0);

    // Reset mid-stream with three halfwords held
    push(16'h0013); tick();
    push(16'h0000); tick();
    push(16'h4501); tick();
    chk("mr_valid_pre", 32'(bus.instr_valid), 32'd1);
    rst = 1'b1;
    push(16'h4509);
    complete(2'b10);
    tick();
    idle();
    chk("mr_ready", 32'(bus.mem_data_ready), 32'd1);
    chk("mr_valid", 32'(bus.instr_valid), 32'd0);
    chk("mr_pc", 32'(bus.instr_pc), 32'd0);
    chk("mr_fstart", 32'(bus.fetch_start), 32'd0);
    chk("mr_faddr", 32'(bus.fetch_addr), 32'd0);
    rst = 1'b0;
    tick();
    chk("mr_boot_fstart", 32'(bus.fetch_start), 32'd1);
    chk("mr_boot_faddr", 32'(bus.fetch_addr), 32'd0);
    tick();
    chk("mr_boot_end", 32'(bus.fetch_start), 32'd0);
    chk("mr_empty", 32'(bus.instr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
